ahb_rr_arbiter: RTL

AHB_RR_ARBITER -- requirements
Module: ahb_rr_arbiter

---
 rtl/ahb_rr_arbiter.sv | 118 +++++++++++
 1 files changed

// File: rtl/ahb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_rr_arbiter
// Four-master AHB bus arbiter. Round-robin with a per-owner beat quantum,
// locked-transfer protection and SPLIT masking.
//
// Ports
//   HCLK       bus clock
//   HRESETn    asynchronous active-low reset; release is sampled on HCLK
//   HBUSREQx   per-master bus request
//   HLOCKx     per-master locked-transfer request
//   HREADY     transfer complete; low freezes grant, quantum and pointer
//   HRESP      slave response, 2'b11 = SPLIT
//   HSPLIT     per-master split resume from slaves
//   HGRANTx    registered one-hot grant
//   HMASTER    master owning the current address phase
//   HMASTLOCK  current address phase is locked
// ---------------------------------------------------------------------------
module ahb_rr_arbiter #(
   parameter int unsigned QUANTUM        = 4,
   parameter int unsigned DEFAULT_MASTER = 0
) (
   input  logic       HCLK,
   input  logic       HRESETn,
   input  logic [3:0] HBUSREQx,
   input  logic [3:0] HLOCKx,
   input  logic       HREADY,
   input  logic [1:0] HRESP,
   input  logic [3:0] HSPLIT,
   output logic [3:0] HGRANTx,
   output logic [1:0] HMASTER,
   output logic       HMASTLOCK
);

   localparam int unsigned NM = 4;
   localparam int unsigned QW = 4;
   localparam logic [1:0]    DEF_IDX   = 2'(DEFAULT_MASTER);
   localparam logic [3:0]    DEF_GRANT = 4'(4'b0001 << DEF_IDX);
   localparam logic [QW-1:0] QLOAD     = QW'(QUANTUM - 1);
   localparam logic [1:0]    RESP_SPLIT = 2'b11;

   logic          run_q;     // set one edge after reset release
   logic [1:0]    owner_q;   // index of HGRANTx, also the RR pointer
   logic [QW-1:0] qcnt_q;    // remaining quantum beats of the owner
   logic [3:0]    mask_q;    // split mask, bit i blocks master i

   logic [3:0]    eligible_c;
   logic          owner_elig_c;
   logic          others_elig_c;
   logic          rearb_c;
   logic [1:0]    winner_c;
   logic [1:0]    next_owner_c;
   logic          grant_chg_c;
   logic [3:0]    split_set_c;
   logic [3:0]    mask_d_c;

   // Arbitration decision for the next HREADY=1 edge
   always_comb begin
      logic       found;
      logic [1:0] idx;
      eligible_c    = HBUSREQx & ~mask_q;
      owner_elig_c  = eligible_c[owner_q];
      others_elig_c = |(eligible_c & ~HGRANTx);
      // A locked owner only escapes quantum preemption, never ineligibility
      rearb_c = !owner_elig_c ||
                ((qcnt_q == '0) && others_elig_c && !HLOCKx[owner_q]);

      // Search owner+1 .. owner+3, then owner itself last
      winner_c = DEF_IDX;
      found    = 1'b0;
      for (int unsigned i = 1; i <= NM; i++) begin
         idx = owner_q + 2'(i);
         if (!found && eligible_c[idx]) begin
            winner_c = idx;
            found    = 1'b1;
         end
      end

      next_owner_c = rearb_c ? winner_c : owner_q;
      grant_chg_c  = (next_owner_c != owner_q);
   end

   // Split mask update; a resume clears even a same-cycle set
   always_comb begin
      split_set_c = '0;
      if (!HREADY && (HRESP == RESP_SPLIT))
         split_set_c = 4'(4'b0001 << HMASTER);
      mask_d_c = (mask_q | split_set_c) & ~HSPLIT;
   end

   // State registers
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         run_q     <= 1'b0;
         owner_q   <= DEF_IDX;
         HGRANTx   <= DEF_GRANT;
         HMASTER   <= DEF_IDX;
         HMASTLOCK <= 1'b0;
         qcnt_q    <= QLOAD;
         mask_q    <= '0;
      end else begin
         run_q <= 1'b1;
         if (run_q) begin
            mask_q <= mask_d_c;
            if (HREADY) begin
               owner_q   <= next_owner_c;
               HGRANTx   <= 4'(4'b0001 << next_owner_c);
               HMASTER   <= owner_q;
               HMASTLOCK <= HLOCKx[owner_q];
               if (grant_chg_c)
                  qcnt_q <= QLOAD;
               else if (qcnt_q != '0)
                  qcnt_q <= qcnt_q - QW'(1);
            end
         end
      end
   end

endmodule
